rr_mux_n_ch: RTL

- Parametrised n-bit, CH-channel multiplexer with round-robin arbitration and one registered output stage.
- Uses valid/ready handshake on every input channel and on the output.
- Sits between multiple requesters and a single consumer in the datapath, for example merging writeback sources or memory request sources.
- Replaces fixed-select 2:1 selection where several producers contend and fairness plus backpressure are required.

---
 rtl/rr_mux_n_ch.sv | 103 ++++++++++
 1 files changed

// File: rtl/rr_mux_n_ch.sv
// Round-robin N-channel multiplexer with valid/ready handshakes and a single
// registered output stage; priority rotates past each granted channel.
module rr_mux_n_ch #(
  parameter int n  = 8,
  parameter int CH = 4,
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*n-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  output logic [n-1:0]    out_data,
  output logic [CH_W-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [n-1:0]    data_q, data_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            valid_q, valid_d;

  logic            can_load;
  logic            any;
  logic [CH_W-1:0] gnt;
  logic [n-1:0]    gnt_data;
  logic [n-1:0]    ch_data [CH];

  for (genvar k = 0; k < CH; k++) begin : g_split
    assign ch_data[k] = in_data[k*n +: n];
  end

  assign can_load = !valid_q || out_ready;
  assign any      = |in_valid;
  // Only the granted lane is selected, so X on idle lanes never reaches the register.
  assign gnt_data = ch_data[gnt];

  // Circular search starting at ptr; the sum is one bit wider so the wrap
  // works for non-power-of-two channel counts.
  always_comb begin : arb
    logic            found;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    gnt   = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      sum = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(CH)) sum = sum - (CH_W+1)'(CH);
      idx = sum[CH_W-1:0];
      if (!found && in_valid[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && can_load && any) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    if (can_load) begin
      if (any) begin
        data_d  = gnt_data;
        ch_d    = gnt;
        valid_d = 1'b1;
        ptr_d   = (gnt == CH_W'(CH-1)) ? '0 : gnt + CH_W'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
  a_ch_range:     assert property (@(posedge clk) disable iff (!rst_n) (32'(out_ch) < CH));

endmodule
